des_decrypt_iter: RTL

- Iterative single-block DES decryptor: the inverse direction of the 16-stage pipelined DES encryptor.
- Runs one Feistel round per clock through a single shared round-function instance, applying subkeys K16 down to K1.
- A right-rotating key schedule generates the subkeys on the fly, so no 768-bit subkey bus is needed.
- Sits on the receive side of the DES datapath behind a valid/ready stream: ciphertext in, plaintext out.

---
 rtl/des_decrypt_iter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock, subkeys K16..K1 generated
// on the fly by right-rotating C/D, valid/ready handshake on both sides.
module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int unsigned IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int unsigned FP_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int unsigned PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int unsigned PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int unsigned P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  // S1..S8, four rows of sixteen 4-bit entries each, first entry in the MSBs
  localparam logic [2047:0] SBOX = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    int unsigned n;
    // E table is regular: box j takes bits 4j..4j+5 (1-based, wrapping)
    for (int unsigned j = 0; j < 8; j++)
      for (int unsigned k6 = 0; k6 < 6; k6++)
        e[6'(47 - (6 * j + k6))] = r[5'(31 - ((4 * j + k6 + 31) % 32))];
    e = e ^ k;
    s = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      b = e[6'(47 - 6 * j) -: 6];
      n = 64 * j + 32 * 32'(b[5]) + 16 * 32'(b[0]) + 32'(b[4:1]);
      s[5'(31 - 4 * j) -: 4] = SBOX[11'(2047 - 4 * n) -: 4];
    end
    for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d, r_new;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] data_out_q, data_out_d, ip_blk;
  logic [55:0] cd0;
  logic        accept, rot1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      l_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      rnd_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      r_q        <= r_d;
      c_q        <= c_d;
      d_q        <= d_d;
      rnd_q      <= rnd_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (rnd_q == 4'd15) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round 0 uses unrotated C0/D0 (encrypt shifts total 28); then undo shifts 16..2
  always_comb begin
    ip_blk     = ip_perm(data_in);
    cd0        = pc1_perm(key);
    r_new      = l_q ^ f_round(r_q, pc2_perm({c_q, d_q}));
    rot1       = (rnd_q == 4'd0) || (rnd_q == 4'd7) || (rnd_q == 4'd14);
    l_d        = l_q;
    r_d        = r_q;
    c_d        = c_q;
    d_d        = d_q;
    rnd_d      = rnd_q;
    data_out_d = data_out_q;
    if (accept) begin
      l_d   = ip_blk[63:32];
      r_d   = ip_blk[31:0];
      c_d   = cd0[55:28];
      d_d   = cd0[27:0];
      rnd_d = '0;
    end else if (state_q == ROUND) begin
      l_d   = r_q;
      r_d   = r_new;
      c_d   = rot1 ? {c_q[0], c_q[27:1]} : {c_q[1:0], c_q[27:2]};
      d_d   = rot1 ? {d_q[0], d_q[27:1]} : {d_q[1:0], d_q[27:2]};
      rnd_d = rnd_q + 4'd1;
      if (rnd_q == 4'd15) data_out_d = fp_perm({r_new, r_q});
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    data_out  = data_out_q;
    accept    = in_valid && in_ready;
  end
endmodule
